// File: rtl/program_loader.sv
// rtl/program_loader.sv - length-prefixed, checksummed byte-stream boot loader for instruction memory
module program_loader #(
    parameter int          MAX_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_write_enable,
    output logic        cpu_reset_n,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  byte_cnt;
    logic [23:0] len_buf;
    logic [15:0] n_words;
    logic [23:0] word_buf;
    logic [7:0]  checksum;

    logic        xfer;
    logic        last_byte;
    logic [7:0]  sum_next;
    logic [31:0] len_full;
    logic [31:0] word_full;
    logic [15:0] loaded_inc;

    always_comb begin
        in_ready   = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
        xfer       = in_valid && in_ready;
        last_byte  = (byte_cnt == 2'd3);
        sum_next   = checksum + in_data;
        len_full   = {in_data, len_buf};
        word_full  = {in_data, word_buf};
        loaded_inc = words_loaded + 16'd1;
        // Gating with reset keeps a reset asserted during WRITE from producing a strobe.
        mem_write_enable = (state == S_WRITE) && !reset;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_LEN: begin
                if (xfer && last_byte) begin
                    if (len_full > 32'(MAX_WORDS)) begin
                        state_next = S_ERROR;
                    end else if (len_full == 32'd0) begin
                        state_next = S_CSUM;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer && last_byte) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (loaded_inc == n_words) begin
                    state_next = S_CSUM;
                end else begin
                    state_next = S_DATA;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_next = (sum_next == 8'd0) ? S_DONE : S_ERROR;
                end
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_LEN;
            byte_cnt     <= 2'd0;
            len_buf      <= 24'd0;
            n_words      <= 16'd0;
            word_buf     <= 24'd0;
            checksum     <= 8'd0;
            words_loaded <= 16'd0;
            mem_address  <= BASE_ADDRESS;
            mem_data_in  <= 32'd0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_reset_n  <= 1'b0;
        end else begin
            state       <= state_next;
            done        <= (state_next == S_DONE);
            error       <= (state_next == S_ERROR);
            cpu_reset_n <= (state_next == S_DONE);

            if (xfer) begin
                checksum <= sum_next;
                byte_cnt <= byte_cnt + 2'd1;
                // The 4th byte of each group is consumed straight from in_data.
                if (state == S_LEN && !last_byte) begin
                    len_buf[{byte_cnt, 3'b000} +: 8] <= in_data;
                end
                if (state == S_DATA && !last_byte) begin
                    word_buf[{byte_cnt, 3'b000} +: 8] <= in_data;
                end
            end

            if (state == S_LEN && xfer && last_byte) begin
                n_words <= len_full[15:0];
            end

            if (state == S_DATA && xfer && last_byte) begin
                mem_data_in <= word_full;
                mem_address <= BASE_ADDRESS + {14'd0, words_loaded, 2'b00};
            end

            if (state == S_WRITE) begin
                words_loaded <= loaded_inc;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed vector bench for program_loader
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_write_enable;
    logic        cpu_reset_n;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    program_loader #(
        .MAX_WORDS(1024),
        .BASE_ADDRESS(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .mem_address(mem_address),
        .mem_data_in(mem_data_in),
        .mem_write_enable(mem_write_enable),
        .cpu_reset_n(cpu_reset_n),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:15][7:0] img;
        int               len;
        logic             exp_done;
        logic             exp_error;
        logic [15:0]      exp_words;
        int               exp_writes;
        logic [31:0]      a0;
        logic [31:0]      d0;
        logic [31:0]      a1;
        logic [31:0]      d1;
    } vec_t;

    vec_t vecs[6];

    int passed = 0;
    int total = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          long_strobes = 0;
    int          overlap = 0;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (mem_write_enable) begin
            wr_addr.push_back(mem_address);
            wr_data.push_back(mem_data_in);
            if (prev_we) long_strobes++;
            if (in_ready) overlap++;
        end
        prev_we = mem_write_enable;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        long_strobes = 0;
        overlap = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_log();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            ok = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            ok = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_range(input vec_t v, input int first, input int last, input int max_gap,
                              output bit all_ok);
        bit ok;
        all_ok = 1'b1;
        for (int k = first; k <= last; k++) begin
            send_byte(v.img[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, ok);
            if (!ok) all_ok = 1'b0;
        end
    endtask

    task automatic verify(input vec_t v, input string tag);
        logic [31:0] a;
        logic [31:0] d;
        check({tag, "_done"}, {31'd0, done}, {31'd0, v.exp_done});
        check({tag, "_error"}, {31'd0, error}, {31'd0, v.exp_error});
        check({tag, "_cpu_reset_n"}, {31'd0, cpu_reset_n}, {31'd0, v.exp_done});
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_words_loaded"}, {16'd0, words_loaded}, {16'd0, v.exp_words});
        check({tag, "_write_count"}, wr_addr.size(), v.exp_writes);
        check({tag, "_strobe_width"}, long_strobes, 32'd0);
        check({tag, "_ready_in_write"}, overlap, 32'd0);
        if (v.exp_writes >= 1) begin
            a = (wr_addr.size() > 0) ? wr_addr[0] : 32'hFFFF_FFFF;
            d = (wr_data.size() > 0) ? wr_data[0] : 32'hFFFF_FFFF;
            check({tag, "_addr0"}, a, v.a0);
            check({tag, "_data0"}, d, v.d0);
        end
        if (v.exp_writes >= 2) begin
            a = (wr_addr.size() > 1) ? wr_addr[1] : 32'hFFFF_FFFF;
            d = (wr_data.size() > 1) ? wr_data[1] : 32'hFFFF_FFFF;
            check({tag, "_addr1"}, a, v.a1);
            check({tag, "_data1"}, d, v.d1);
        end
    endtask

    task automatic run_image(input vec_t v, input int max_gap, input string tag);
        bit all_ok;
        send_range(v, 0, v.len - 1, max_gap, all_ok);
        check({tag, "_accepted"}, {31'd0, all_ok}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        verify(v, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_we"}, {31'd0, mem_write_enable}, 32'd0);
        check({tag, "_addr"}, mem_address, 32'd0);
        check({tag, "_data"}, mem_data_in, 32'd0);
        check({tag, "_cpu_reset_n"}, {31'd0, cpu_reset_n}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        vecs[0] = '{img: {8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                          8'h13, 8'h81, 8'h10, 8'h00, 8'h77, 24'h0},
                    len: 13, exp_done: 1'b1, exp_error: 1'b0, exp_words: 16'd2, exp_writes: 2,
                    a0: 32'h0, d0: 32'h0050_0093, a1: 32'h4, d1: 32'h0010_8113};
        vecs[1] = '{img: '0, len: 5, exp_done: 1'b1, exp_error: 1'b0, exp_words: 16'd0,
                    exp_writes: 0, a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0};
        vecs[2] = vecs[0];
        vecs[2].img[12] = 8'h78;
        vecs[2].exp_done = 1'b0;
        vecs[2].exp_error = 1'b1;
        vecs[3] = '{img: {8'h01, 8'h04, 8'h00, 8'h00, 96'h0},
                    len: 4, exp_done: 1'b0, exp_error: 1'b1, exp_words: 16'd0, exp_writes: 0,
                    a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0};
        vecs[4] = '{img: {8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hC7, 56'h0},
                    len: 9, exp_done: 1'b1, exp_error: 1'b0, exp_words: 16'd1, exp_writes: 1,
                    a0: 32'h0, d0: 32'hDEAD_BEEF, a1: 32'h0, d1: 32'h0};
        vecs[5] = '{img: {8'h00, 8'h00, 8'h01, 8'h00, 96'h0},
                    len: 4, exp_done: 1'b0, exp_error: 1'b1, exp_words: 16'd0, exp_writes: 0,
                    a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0};

        do_reset();
        check_reset_outputs("reset");

        for (int i = 0; i < 6; i++) begin
            do_reset();
            run_image(vecs[i], 0, $sformatf("v%0d", i));
        end

        // Write latency and done timing, byte by byte.
        do_reset();
        send_range(vecs[0], 0, 7, 0, ok);
        check("lat_accept", {31'd0, ok}, 32'd1);
        check("lat_we", {31'd0, mem_write_enable}, 32'd1);
        check("lat_ready", {31'd0, in_ready}, 32'd0);
        check("lat_addr", mem_address, 32'h0);
        check("lat_data", mem_data_in, 32'h0050_0093);
        @(posedge clk);
        #1;
        check("lat_words_after", {16'd0, words_loaded}, 32'd1);
        check("lat_we_after", {31'd0, mem_write_enable}, 32'd0);
        send_range(vecs[0], 8, 11, 0, ok);
        check("lat_done_before", {31'd0, done}, 32'd0);
        send_byte(8'h77, 0, ok);
        check("lat_done", {31'd0, done}, 32'd1);
        check("lat_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd1);

        do_reset();
        run_image(vecs[0], 5, "gaps");

        // Reset after 6 bytes, then replay the full image.
        do_reset();
        send_range(vecs[0], 0, 5, 0, ok);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        clear_log();
        run_image(vecs[0], 0, "replay");

        // Input offered after DONE must be ignored.
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("done_hold_words", {16'd0, words_loaded}, 32'd2);
        check("done_hold_done", {31'd0, done}, 32'd1);
        check("done_hold_writes", wr_addr.size(), 32'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("done_reset_cpu", {31'd0, cpu_reset_n}, 32'd0);
        check("done_reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        // Reset landing in the WRITE cycle.
        do_reset();
        send_range(vecs[0], 0, 7, 0, ok);
        reset = 1'b1;
        #1;
        check("wr_reset_we", {31'd0, mem_write_enable}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("wr_reset_words", {16'd0, words_loaded}, 32'd0);
        check("wr_reset_ready", {31'd0, in_ready}, 32'd1);
        check("wr_reset_data", mem_data_in, 32'd0);
        check("wr_reset_writes", wr_addr.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream boot loader that writes the instruction memory the CPU fetches from. It is the writer for the instruction-fetch read port.
- Receives a length-prefixed, checksummed program image over a valid/ready byte interface. Assembles little-endian 32-bit words and issues one-cycle write strobes to the instruction memory's write port.
- Holds the CPU in reset until the whole image is loaded and the checksum verifies.

Parameters:
- MAX_WORDS, 1024: maximum accepted word count (1..65535).
- BASE_ADDRESS, 32'h0000_0000: byte address of the first written word.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a valid byte.
- in_ready  output  1  loader can accept a byte this cycle.
- in_data  input  8  stream byte.
- mem_address  output  32  instruction memory byte address.
- mem_data_in  output  32  word to write.
- mem_write_enable  output  1  one-cycle write strobe.
- cpu_reset_n  output  1  drives the CPU reset input; 0 holds the CPU in reset.
- done  output  1  image loaded and verified (sticky).
- error  output  1  load failed (sticky).
- words_loaded  output  16  count of words written so far.

Behaviour:
- Reset state:
  - Loader enters LEN with all counters and the checksum cleared.
  - in_ready=1, mem_write_enable=0, mem_address=BASE_ADDRESS, mem_data_in=0.
  - cpu_reset_n=0, done=0, error=0, words_loaded=0.
- Handshake:
  - A byte transfers on a rising edge where in_valid=1 and in_ready=1.
  - in_ready is a pure function of state: 1 in LEN, DATA and CSUM; 0 in WRITE, DONE and ERROR.
  - in_valid gaps of any length are legal; state holds until the next transfer.
- Image format: 4-byte word count N, little-endian, then N words of 4 bytes each (little-endian), then 1 checksum byte.
  - The 8-bit modular sum of all bytes, count and checksum byte included, must equal 0x00.
- Checksum accumulator: 8-bit, wraps modulo 256, updated on every transferred byte.
- LEN state:
  - Collects 4 bytes into N.
  - On the 4th byte: N > MAX_WORDS -> ERROR; N == 0 -> CSUM; otherwise -> DATA.
- DATA state: collects 4 bytes into a word buffer (first byte goes to bits [7:0]); after the 4th byte -> WRITE.
- WRITE state (exactly one cycle):
  - mem_write_enable=1, mem_data_in=word, mem_address = BASE_ADDRESS + 4*words_loaded (32-bit wrap).
  - Next edge: words_loaded increments. If the new count equals N -> CSUM, else -> DATA.
  - Write latency: the strobe asserts in the cycle after the edge that accepts a word's 4th byte.
- CSUM state: accepts 1 byte. Final sum == 0 -> DONE, else -> ERROR.
- DONE state (terminal):
  - done=1, cpu_reset_n=1, in_ready=0.
  - Further input is ignored (never accepted) until reset.
- ERROR state (terminal):
  - error=1, cpu_reset_n=0, in_ready=0.
  - Memory contents already written are not rolled back.
- Output timing: done, error and cpu_reset_n are registered and change on the same edge as the state transition. done and error are never both 1.
- mem_write_enable: high only in WRITE. mem_address and mem_data_in hold their last values outside WRITE.
- Reset at any point, including mid-word or during WRITE, returns to the reset state next edge:
  - partial word discarded;
  - cpu_reset_n drops to 0 even from DONE;
  - no write strobe is issued in the reset cycle.
- No simultaneous-event ambiguity: one byte per cycle at most, and writes occur only in WRITE, where no byte is accepted.

Test Plan:
- Two-word load. Stream 02 00 00 00 93 00 50 00 13 81 10 00 77:
  - write 0x00500093 @0x0, then 0x00108113 @0x4, each a single-cycle strobe;
  - words_loaded=2; done=1 and cpu_reset_n=1 one edge after the 0x77 byte.
- Zero length. Stream 00 00 00 00 00 -> no mem_write_enable pulse; done=1; words_loaded=0.
- Bad checksum. Same two-word image with the last byte 0x78:
  - both writes still occur;
  - error=1, done=0, cpu_reset_n stays 0, in_ready=0 afterwards.
- Oversize. With MAX_WORDS=1024, count bytes 01 04 00 00 (N=1025) -> error=1 on the 4th byte; no writes.
- Backpressure and gaps:
  - Two-word image with random in_valid idle cycles (0-5), and in_valid held high during WRITE.
  - Results identical to the two-word load; no byte lost or duplicated across WRITE cycles (in_ready=0 there).
- Reset mid-load:
  - Assert reset after 6 bytes of the two-word image; all outputs return to reset values on the next edge.
  - Replaying the full image then yields done=1, with the correct words at 0x0 and 0x4.
